// File: rtl/sec_pkg.sv
// Shared definitions for the security sequencer: state encoding, Z values and sizing helpers.
package sec_pkg;

  typedef enum logic [2:0] {
    ST_DISARMED = 3'd0,
    ST_EXIT     = 3'd1,
    ST_ARMED    = 3'd2,
    ST_ENTRY    = 3'd3,
    ST_ALARM    = 3'd4,
    ST_LOCKOUT  = 3'd5
  } sec_state_t;

  localparam logic [2:0] Z_DISARMED = 3'd0;
  localparam logic [2:0] Z_EXIT     = 3'd1;
  localparam logic [2:0] Z_ARMED    = 3'd2;
  localparam logic [2:0] Z_ENTRY    = 3'd3;
  localparam logic [2:0] Z_ALARM    = 3'd4;
  localparam logic [2:0] Z_LOCKOUT  = 3'd5;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // A count of 1 would give a zero-width vector, so floor the width at one bit.
  function automatic int width_for(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sec_timer.sv
// Loadable down-counter; holds at zero and flags expiry while the count is zero.
module sec_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == '0);

endmodule

// File: rtl/alarm_sequencer.sv
// Security sequencer: arm/exit/entry/siren/lockout timing around code-checker V/E pulses.
module alarm_sequencer
  import sec_pkg::*;
#(
  parameter int EXIT_CYCLES    = 8,
  parameter int ENTRY_CYCLES   = 16,
  parameter int SIREN_CYCLES   = 32,
  parameter int LOCKOUT_CYCLES = 64,
  parameter int MAX_TRIES      = 3,
  localparam int TRW = $clog2(MAX_TRIES + 1)
) (
  input  logic           U,
  input  logic           R,
  input  logic           S,
  input  logic           D,
  input  logic           V,
  input  logic           E,
  output logic [2:0]     Z,
  output logic           A,
  output logic           L,
  output logic [TRW-1:0] T
);

  localparam int TW = width_for(max4(EXIT_CYCLES, ENTRY_CYCLES, SIREN_CYCLES, LOCKOUT_CYCLES));
  localparam logic [TW-1:0] EXIT_LOAD    = TW'(EXIT_CYCLES - 1);
  localparam logic [TW-1:0] ENTRY_LOAD   = TW'(ENTRY_CYCLES - 1);
  localparam logic [TW-1:0] SIREN_LOAD   = TW'(SIREN_CYCLES - 1);
  localparam logic [TW-1:0] LOCKOUT_LOAD = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [TRW:0]  TRIES_LIMIT  = (TRW + 1)'(MAX_TRIES);

  sec_state_t     state_q, state_d;
  logic [TRW-1:0] tries_q, tries_d;
  logic           tmr_load;
  logic [TW-1:0]  tmr_val;
  logic           tmr_expired;
  logic           v_only;
  logic [TRW:0]   tries_plus;
  logic           tries_hit;

  sec_timer #(.W(TW)) u_timer (
    .clk      (U),
    .rst_n    (R),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_expired)
  );

  // A simultaneous V and E is treated as a wrong code only.
  assign v_only     = V & ~E;
  assign tries_plus = {1'b0, tries_q} + 1'b1;
  assign tries_hit  = (tries_plus >= TRIES_LIMIT);

  always_comb begin
    state_d  = state_q;
    tries_d  = tries_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state_q)
      ST_DISARMED: begin
        if (S) begin
          state_d  = ST_EXIT;
          tmr_load = 1'b1;
          tmr_val  = EXIT_LOAD;
        end
      end
      ST_EXIT: begin
        if (!S || v_only) begin
          state_d = ST_DISARMED;
        end else if (tmr_expired) begin
          state_d = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (v_only) begin
          state_d = ST_DISARMED;
        end else if (D) begin
          state_d  = ST_ENTRY;
          tmr_load = 1'b1;
          tmr_val  = ENTRY_LOAD;
        end
      end
      ST_ENTRY: begin
        // Priority: lockout on the limiting E, then a valid code, then expiry.
        if (E) begin
          tries_d = tries_hit ? TRIES_LIMIT[TRW-1:0] : tries_plus[TRW-1:0];
        end
        if (E && tries_hit) begin
          state_d  = ST_LOCKOUT;
          tmr_load = 1'b1;
          tmr_val  = LOCKOUT_LOAD;
        end else if (v_only) begin
          state_d = ST_DISARMED;
          tries_d = '0;
        end else if (tmr_expired) begin
          state_d  = ST_ALARM;
          tmr_load = 1'b1;
          tmr_val  = SIREN_LOAD;
        end
      end
      ST_ALARM: begin
        if (v_only) begin
          state_d = ST_DISARMED;
          tries_d = '0;
        end else if (tmr_expired) begin
          state_d = ST_ARMED;
          tries_d = '0;
        end
      end
      ST_LOCKOUT: begin
        if (tmr_expired) begin
          state_d  = ST_ALARM;
          tries_d  = '0;
          tmr_load = 1'b1;
          tmr_val  = SIREN_LOAD;
        end
      end
      default: begin
        state_d = ST_DISARMED;
      end
    endcase
  end

  always_ff @(posedge U or negedge R) begin
    if (!R) begin
      state_q <= ST_DISARMED;
      tries_q <= '0;
    end else begin
      state_q <= state_d;
      tries_q <= tries_d;
    end
  end

  assign Z = state_q;
  assign A = (state_q == ST_ALARM) || (state_q == ST_LOCKOUT);
  assign L = (state_q == ST_LOCKOUT);
  assign T = tries_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Bench for alarm_sequencer: directed scenarios plus random traffic against a cycle-age reference model.
module tb_alarm_sequencer;
  import sec_pkg::*;

  localparam int EXIT_N    = 2;
  localparam int ENTRY_N   = 4;
  localparam int SIREN_N   = 3;
  localparam int LOCKOUT_N = 5;
  localparam int MAX_T     = 3;
  localparam int TRW       = $clog2(MAX_T + 1);
  localparam int OW        = 3 + 1 + 1 + TRW;

  logic           clk;
  logic           rst_n;
  logic           s_i, d_i, v_i, e_i;
  logic [2:0]     z_o;
  logic           a_o, l_o;
  logic [TRW-1:0] t_o;

  int checks   = 0;
  int failures = 0;
  int cyc_no   = 0;

  logic [OW-1:0] exp_q[$];

  // Reference model: state number, cycles spent in current state, failed tries.
  int m_st, m_age, m_t;

  alarm_sequencer #(
    .EXIT_CYCLES    (EXIT_N),
    .ENTRY_CYCLES   (ENTRY_N),
    .SIREN_CYCLES   (SIREN_N),
    .LOCKOUT_CYCLES (LOCKOUT_N),
    .MAX_TRIES      (MAX_T)
  ) dut (
    .U (clk),
    .R (rst_n),
    .S (s_i),
    .D (d_i),
    .V (v_i),
    .E (e_i),
    .Z (z_o),
    .A (a_o),
    .L (l_o),
    .T (t_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int dur(input int st);
    case (st)
      1: return EXIT_N;
      3: return ENTRY_N;
      4: return SIREN_N;
      5: return LOCKOUT_N;
      default: return 0;
    endcase
  endfunction

  task automatic go(input int st);
    m_st  = st;
    m_age = 0;
  endtask

  task automatic model_step(input logic s, input logic d, input logic v, input logic e);
    bit code_ok;
    bit done;
    code_ok = v && !e;
    done    = (m_age == dur(m_st) - 1);
    case (m_st)
      0: if (s) go(1);
      1: begin
        if (!s || code_ok) go(0);
        else if (done) go(2);
        else m_age++;
      end
      2: begin
        if (code_ok) go(0);
        else if (d) go(3);
      end
      3: begin
        if (e && m_t + 1 >= MAX_T) begin
          m_t = MAX_T;
          go(5);
        end else begin
          if (e) m_t = m_t + 1;
          if (code_ok) begin
            m_t = 0;
            go(0);
          end else if (done) go(4);
          else m_age++;
        end
      end
      4: begin
        if (code_ok) begin
          m_t = 0;
          go(0);
        end else if (done) begin
          m_t = 0;
          go(2);
        end else m_age++;
      end
      5: begin
        if (done) begin
          m_t = 0;
          go(4);
        end else m_age++;
      end
      default: go(0);
    endcase
  endtask

  function automatic logic [OW-1:0] model_out();
    logic [2:0]     z;
    logic [TRW-1:0] t;
    z = 3'(m_st);
    t = TRW'(m_t);
    return {z, (m_st == 4 || m_st == 5), (m_st == 5), t};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic s, input logic d, input logic v, input logic e);
    @(negedge clk);
    s_i = s; d_i = d; v_i = v; e_i = e;
    @(posedge clk);
    model_step(s, d, v, e);
    exp_q.push_back(model_out());
  endtask

  task automatic idle(input int n, input logic s);
    for (int i = 0; i < n; i++) drive(s, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got Z=%0d A=%0b L=%0b T=%0d, expected Z=%0d A=%0b L=%0b T=%0d",
               name, act[OW-1 -: 3], act[TRW+1], act[TRW], act[TRW-1:0],
               exp[OW-1 -: 3], exp[TRW+1], exp[TRW], exp[TRW-1:0]);
    end
  endtask

  // Asynchronous reset asserted between edges; outputs must clear before the next edge.
  task automatic async_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", {z_o, a_o, l_o, t_o}, {Z_DISARMED, 1'b0, 1'b0, {TRW{1'b0}}});
    m_st = 0; m_age = 0; m_t = 0;
    s_i = 1'b0; d_i = 1'b0; v_i = 1'b0; e_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(posedge clk) begin
    #1;
    cyc_no++;
    if (exp_q.size() > 0) begin
      logic [OW-1:0] exp_v;
      exp_v = exp_q.pop_front();
      chk($sformatf("cycle%0d", cyc_no), {z_o, a_o, l_o, t_o}, exp_v);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    s_i = 1'b0; d_i = 1'b0; v_i = 1'b0; e_i = 1'b0;
    m_st = 0; m_age = 0; m_t = 0;
    #12;
    chk("reset_state", {z_o, a_o, l_o, t_o}, {Z_DISARMED, 1'b0, 1'b0, {TRW{1'b0}}});
    @(negedge clk);
    rst_n = 1'b1;

    // Arm: two EXIT cycles then ARMED
    idle(3, 1'b1);
    // Disarm with V on second ENTRY cycle
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    // Re-arm, then entry timeout into ALARM and back to ARMED
    idle(3, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    idle(9, 1'b1);
    // Lockout on three wrong codes; V during lockout ignored
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    idle(9, 1'b1);
    // V&E together counts as E; V alone then disarms
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    // Reset mid-ALARM, then arm again
    idle(3, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    idle(5, 1'b1);
    @(posedge clk);
    #2;
    async_reset();
    idle(4, 1'b1);

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      drive($urandom_range(0, 9) != 0, $urandom_range(0, 5) == 0,
            $urandom_range(0, 11) == 0, $urandom_range(0, 4) == 0);
    end

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
